// File: rtl/gray_seek_ctrl.sv
// gray_seek_ctrl: accepts a binary target over valid/ready, walks a position
// register toward it one unit every DWELL cycles and presents the position both
// in binary and Gray code, so a downstream consumer sees one bit flip per step.
module gray_seek_ctrl #(
    parameter int N     = 4,
    parameter int DWELL = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_target,
    input  logic         abort,
    output logic [N-1:0] pos,
    output logic [N-1:0] g,
    output logic         dir,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  tgt;
    logic [CW-1:0] cnt;
    logic [N-1:0]  next_pos;
    logic          at_limit;

    // Candidate next position and end-of-range guard for the current direction
    always_comb begin
        next_pos = dir ? (pos + 1'b1) : (pos - 1'b1);
        at_limit = dir ? (&pos) : (~|pos);
    end

    // Sequencer: accept, dwell/step toward target, one-cycle done, abort to idle
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pos   <= '0;
            dir   <= 1'b1;
            tgt   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tgt <= req_target;
                        if (req_target == pos) begin
                            state <= DONE;
                        end else begin
                            state <= MOVE;
                            dir   <= (req_target > pos);
                            cnt   <= RELOAD;
                        end
                    end
                end
                MOVE: begin
                    // Abort wins over a step due on the same edge
                    if (abort) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt <= RELOAD;
                        // The path is monotonic, so the limit guard only
                        // protects against a corrupted target.
                        if (!at_limit) begin
                            pos <= next_pos;
                        end
                        if ((next_pos == tgt) || at_limit) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status flags decoded straight from the state register
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state == MOVE);
        done      = (state == DONE);
    end

    // Gray view of the registered position, valid in the same cycle as pos
    always_comb begin
        g = pos ^ {1'b0, pos[N-1:1]};
    end

endmodule
